// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared opcodes, FSM states and datapath register addresses for program_sequencer
package seq_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_LDB = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_OUT = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  localparam logic [1:0] RA_A    = 2'd0;
  localparam logic [1:0] RA_B    = 2'd1;
  localparam logic [1:0] RA_OUT  = 2'd2;
  localparam logic [1:0] RA_NONE = 2'd3;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational decode of the instruction register into datapath controls and branch info
module instr_decoder
  import seq_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int PC_WIDTH  = 4
) (
  input  logic [BIT_WIDTH+3:0] ir,
  input  logic                 c_flag,
  output logic [BIT_WIDTH-1:0] dp_in,
  output logic [1:0]           dp_reg_addr,
  output logic                 dp_s_reg,
  output logic                 dp_s,
  output logic                 jump_en,
  output logic [PC_WIDTH-1:0]  jump_target,
  output logic                 is_alu,
  output logic                 is_hlt
);

  logic [3:0]           opcode;
  logic [BIT_WIDTH-1:0] operand;

  assign opcode      = ir[BIT_WIDTH+3:BIT_WIDTH];
  assign operand     = ir[BIT_WIDTH-1:0];
  assign jump_target = operand[PC_WIDTH-1:0];

  always_comb begin
    dp_in       = '0;
    dp_reg_addr = RA_NONE;
    dp_s_reg    = 1'b0;
    dp_s        = 1'b0;
    jump_en     = 1'b0;
    is_alu      = 1'b0;
    is_hlt      = 1'b0;
    case (opcode)
      OP_LDA: begin
        dp_s_reg    = 1'b1;
        dp_reg_addr = RA_A;
        dp_in       = operand;
      end
      OP_LDB: begin
        dp_s_reg    = 1'b1;
        dp_reg_addr = RA_B;
        dp_in       = operand;
      end
      OP_ADD: begin
        dp_reg_addr = RA_A;
        is_alu      = 1'b1;
      end
      OP_SUB: begin
        dp_reg_addr = RA_A;
        dp_s        = 1'b1;
        is_alu      = 1'b1;
      end
      OP_OUT:  dp_reg_addr = RA_OUT;
      OP_JMP:  jump_en = 1'b1;
      OP_JC:   jump_en = c_flag;
      OP_HLT:  is_hlt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - FETCH/EXEC instruction sequencer driving the register/ALU datapath; SINGLE_STEP_EN adds step/PAUSE
module program_sequencer
  import seq_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int PC_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic [PC_WIDTH-1:0]  instr_addr,
  input  logic [BIT_WIDTH+3:0] instr_data,
  output logic [BIT_WIDTH-1:0] dp_in,
  output logic [1:0]           dp_reg_addr,
  output logic                 dp_s_reg,
  output logic                 dp_s,
  input  logic                 dp_cout,
  output logic                 busy,
  output logic                 halted
);

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [BIT_WIDTH+3:0] ir_q;
  logic                 c_flag_q;
  logic                 alu_pend_q;
  logic                 dp_s_q;

  logic [BIT_WIDTH-1:0] dec_in;
  logic [1:0]           dec_reg_addr;
  logic                 dec_s_reg;
  logic                 dec_s;
  logic                 jump_en;
  logic [PC_WIDTH-1:0]  jump_target;
  logic                 is_alu;
  logic                 is_hlt;

  instr_decoder #(
    .BIT_WIDTH (BIT_WIDTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_decoder (
    .ir          (ir_q),
    .c_flag      (c_flag_q),
    .dp_in       (dec_in),
    .dp_reg_addr (dec_reg_addr),
    .dp_s_reg    (dec_s_reg),
    .dp_s        (dec_s),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .is_alu      (is_alu),
    .is_hlt      (is_hlt)
  );

  assign instr_addr = pc_q;

  // Controls are combinational from state so a reset takes them off the datapath on the next cycle.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    halted      = 1'b0;
    dp_reg_addr = RA_NONE;
    dp_s_reg    = 1'b0;
    dp_in       = '0;
    dp_s        = dp_s_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy        = 1'b1;
        dp_reg_addr = dec_reg_addr;
        dp_s_reg    = dec_s_reg;
        dp_in       = dec_in;
        if (is_alu) dp_s = dec_s;
`ifdef SINGLE_STEP_EN
        state_d = is_hlt ? S_HALT : S_PAUSE;
`else
        state_d = is_hlt ? S_HALT : S_FETCH;
`endif
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_d = S_FETCH;
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        busy = 1'b1;
        if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      c_flag_q   <= 1'b0;
      alu_pend_q <= 1'b0;
      dp_s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: begin
          ir_q <= instr_data;
          // The datapath carry register is valid one cycle after the ADD/SUB write.
          if (alu_pend_q) begin
            c_flag_q   <= dp_cout;
            alu_pend_q <= 1'b0;
          end
        end
        S_EXEC: begin
          if (is_alu) begin
            alu_pend_q <= 1'b1;
            dp_s_q     <= dec_s;
          end
          if (jump_en)      pc_q <= jump_target;
          else if (!is_hlt) pc_q <= pc_q + PC_WIDTH'(1);
        end
        S_HALT: begin
          if (start) begin
            pc_q     <= '0;
            c_flag_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
